mips_processor: RTL and testbench

//  Single-cycle 32-bit MIPS-subset core with word-addressed on-chip instruction and data memories.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_processor_if.sv | 23 ++
 rtl/mips_alu.sv | 29 ++
 rtl/mips_processor.sv | 181 ++++++++++++++++++
 tb/tb_mips_processor.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: memory sizes, opcode/funct codes, ALU operations.
package mips_pkg;

    localparam int IMEM_AW = 10;
    localparam int DMEM_AW = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_processor_if.sv
// Instruction-load port and debug write-back observation port of the MIPS core.
interface mips_processor_if;
    import mips_pkg::*;

    logic [IMEM_AW-1:0] init_pc;
    logic               instr_we;
    logic [31:0]        instr_feed;
    logic [IMEM_AW-1:0] dbg_pc;
    logic               dbg_wb_en;
    logic [4:0]         dbg_wb_addr;
    logic [31:0]        dbg_wb_data;

    modport master (
        output init_pc, instr_we, instr_feed,
        input  dbg_pc, dbg_wb_en, dbg_wb_addr, dbg_wb_data
    );

    modport slave (
        input  init_pc, instr_we, instr_feed,
        output dbg_pc, dbg_wb_en, dbg_wb_addr, dbg_wb_data
    );

endinterface

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU; zero flag drives beq/bne resolution.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    input  logic [4:0]  shamt,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            default: y = '0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/mips_processor.sv
// Single-cycle MIPS-subset core; imem streamed in while instr_we=1, then one instruction per clock.
// Build with SHIFT_OPS_EN defined to decode sll/srl; otherwise those functs are NOPs.
module mips_processor
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mips_processor_if.slave  bus
);

    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] load_ptr;
    logic [31:0]        imem [2**IMEM_AW];
    logic [31:0]        dmem [2**DMEM_AW];
    logic [31:0]        regs [32];

    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign instr = imem[pc];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    alu_op_t     alu_op;
    logic [31:0] alu_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;

    always_comb begin
        alu_op  = ALU_ADD;
        alu_b   = rt_val;
        wr_en   = 1'b0;
        wr_addr = rd;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin alu_op = ALU_ADD; wr_en = 1'b1; end
                    FN_SUB: begin alu_op = ALU_SUB; wr_en = 1'b1; end
                    FN_AND: begin alu_op = ALU_AND; wr_en = 1'b1; end
                    FN_OR:  begin alu_op = ALU_OR;  wr_en = 1'b1; end
                    FN_SLT: begin alu_op = ALU_SLT; wr_en = 1'b1; end
`ifdef SHIFT_OPS_EN
                    FN_SLL: begin alu_op = ALU_SLL; wr_en = 1'b1; end
                    FN_SRL: begin alu_op = ALU_SRL; wr_en = 1'b1; end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin
                alu_b   = sext16(imm);
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            OP_ANDI: begin
                alu_op  = ALU_AND;
                alu_b   = {16'd0, imm};
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            OP_ORI: begin
                alu_op  = ALU_OR;
                alu_b   = {16'd0, imm};
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            OP_LW: begin
                alu_b   = sext16(imm);
                mem_rd  = 1'b1;
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            OP_SW: begin
                alu_b  = sext16(imm);
                mem_wr = 1'b1;
            end
            OP_BEQ: begin alu_op = ALU_SUB; is_beq = 1'b1; end
            OP_BNE: begin alu_op = ALU_SUB; is_bne = 1'b1; end
            OP_J:   is_j = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] alu_y;
    logic        alu_zero;

    mips_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .shamt  (shamt),
        .y      (alu_y),
        .zero   (alu_zero)
    );

    logic               run;
    logic               wb_fire;
    logic [DMEM_AW-1:0] dmem_idx;
    logic [31:0]        wb_data;

    // Byte address to word index; upper address bits fold away modulo the dmem size.
    assign dmem_idx = alu_y[DMEM_AW+1:2];
    assign run      = !rst && !bus.instr_we;
    assign wb_fire  = run && wr_en && (wr_addr != 5'd0);
    assign wb_data  = mem_rd ? dmem[dmem_idx] : alu_y;

    logic [IMEM_AW-1:0] pc_inc;
    logic [IMEM_AW-1:0] pc_next;
    logic               taken;

    assign pc_inc  = pc + IMEM_AW'(1);
    assign taken   = (is_beq && alu_zero) || (is_bne && !alu_zero);
    assign pc_next = is_j  ? instr[IMEM_AW-1:0] :
                     taken ? pc_inc + imm[IMEM_AW-1:0] :
                             pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= bus.init_pc;
            load_ptr <= bus.init_pc;
        end else if (bus.instr_we) begin
            load_ptr <= load_ptr + IMEM_AW'(1);
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            regs[wr_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.instr_we) begin
            imem[load_ptr] <= bus.instr_feed;
        end
    end

    always_ff @(posedge clk) begin
        if (run && mem_wr) begin
            dmem[dmem_idx] <= rt_val;
        end
    end

    assign bus.dbg_pc      = pc;
    assign bus.dbg_wb_en   = wb_fire;
    assign bus.dbg_wb_addr = wb_fire ? wr_addr : 5'd0;
    assign bus.dbg_wb_data = wb_fire ? wb_data : 32'd0;

endmodule

// File: tb/tb_mips_processor.sv
// Directed program bench for mips_processor: loads short programs and checks the write-back trace.
module tb_mips_processor;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mips_processor_if bus();

    mips_processor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: one rst cycle, then outputs checked with rst still high.
    task automatic do_reset(input int pc);
        rst          = 1'b1;
        bus.instr_we = 1'b0;
        bus.init_pc  = 10'(pc);
        @(negedge clk);
        #1;
        check("rst pc",   32'(bus.dbg_pc), pc);
        check("rst en",   32'(bus.dbg_wb_en), 0);
        check("rst addr", 32'(bus.dbg_wb_addr), 0);
        check("rst data", bus.dbg_wb_data, 0);
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w, input int exp_pc);
        bus.instr_we   = 1'b1;
        bus.instr_feed = w;
        #1;
        check("load pc", 32'(bus.dbg_pc), exp_pc);
        check("load en", 32'(bus.dbg_wb_en), 0);
        @(negedge clk);
    endtask

    task automatic exec(input string tag, input int exp_pc, input bit exp_en,
                        input logic [4:0] exp_addr, input logic [31:0] exp_data);
        bus.instr_we = 1'b0;
        #1;
        check({tag, " pc"}, 32'(bus.dbg_pc), exp_pc);
        check({tag, " en"}, 32'(bus.dbg_wb_en), 32'(exp_en));
        if (exp_en) begin
            check({tag, " addr"}, 32'(bus.dbg_wb_addr), 32'(exp_addr));
            check({tag, " data"}, bus.dbg_wb_data, exp_data);
        end
        @(negedge clk);
    endtask

    logic [31:0] prog1 [3]  = '{32'h20010005, 32'h20020007, 32'h00221820};
    logic [31:0] prog1b[3]  = '{32'hAC030004, 32'h8C040004, 32'h1000FFFF};
    logic [31:0] prog2 [12] = '{32'h2001FFFF, 32'h0020282A, 32'h20000009, 32'h20070003,
                                32'h00014022, 32'h00274824, 32'h34EA8000, 32'h302BF0F0,
                                32'h10010005, 32'h14010001, 32'h20010063, 32'h08000005};
    logic [31:0] prog3 [6]  = '{32'h20010001, 32'h20020002, 32'h20030003,
                                32'h20040004, 32'h20050005, 32'h20060006};
    logic [31:0] prog4 [5]  = '{32'h00640820, 32'h20010011, 32'h00016100,
                                32'h00016902, 32'h1000FFFF};

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.instr_we   = 1'b0;
        bus.instr_feed = '0;
        bus.init_pc    = '0;
        @(negedge clk);

        // Basic addi/add sequence from pc 0
        do_reset(0);
        for (int i = 0; i < 3; i++) load_word(prog1[i], 0);
        exec("addi1", 0, 1'b1, 5'd1, 32'd5);
        exec("addi2", 1, 1'b1, 5'd2, 32'd7);
        exec("add3",  2, 1'b1, 5'd3, 32'd12);

        // Stall mid-run at pc 3, append sw/lw/beq at load_ptr 3
        for (int i = 0; i < 3; i++) load_word(prog1b[i], 3);
        exec("sw",    3, 1'b0, 5'd0, 32'd0);
        exec("lw",    4, 1'b1, 5'd4, 32'd12);
        exec("beqA",  5, 1'b0, 5'd0, 32'd0);
        exec("beqB",  5, 1'b0, 5'd0, 32'd0);
        exec("beqC",  5, 1'b0, 5'd0, 32'd0);

        // Logic ops, slt, $0 write, branches, jump
        do_reset(10);
        for (int i = 0; i < 12; i++) load_word(prog2[i], 10);
        exec("addi-1", 10, 1'b1, 5'd1,  32'hFFFFFFFF);
        exec("slt",    11, 1'b1, 5'd5,  32'd1);
        exec("wr$0",   12, 1'b0, 5'd0,  32'd0);
        exec("rd$0",   13, 1'b1, 5'd7,  32'd3);
        exec("sub",    14, 1'b1, 5'd8,  32'd1);
        exec("and",    15, 1'b1, 5'd9,  32'd3);
        exec("ori",    16, 1'b1, 5'd10, 32'h00008003);
        exec("andi",   17, 1'b1, 5'd11, 32'h0000F0F0);
        exec("beqNT",  18, 1'b0, 5'd0,  32'd0);
        exec("bneT",   19, 1'b0, 5'd0,  32'd0);
        exec("j",      21, 1'b0, 5'd0,  32'd0);
        exec("jdst",    5, 1'b0, 5'd0,  32'd0);

        // Load wraps imem 1023->0; execution wraps pc likewise
        do_reset(1020);
        for (int i = 0; i < 6; i++) load_word(prog3[i], 1020);
        exec("w1",   1020, 1'b1, 5'd1, 32'd1);
        exec("w2",   1021, 1'b1, 5'd2, 32'd2);
        exec("w3",   1022, 1'b1, 5'd3, 32'd3);
        exec("w4",   1023, 1'b1, 5'd4, 32'd4);
        exec("w5",      0, 1'b1, 5'd5, 32'd5);
        exec("w6",      1, 1'b1, 5'd6, 32'd6);
        exec("wadd",    2, 1'b1, 5'd3, 32'd3);
        exec("wsw",     3, 1'b0, 5'd0, 32'd0);
        exec("wlw",     4, 1'b1, 5'd4, 32'd3);
        exec("wbeq",    5, 1'b0, 5'd0, 32'd0);

        // Reset mid-run: registers $3/$4 (both 3) must read back as 0
        do_reset(100);
        for (int i = 0; i < 5; i++) load_word(prog4[i], 100);
        exec("clr",   100, 1'b1, 5'd1, 32'd0);
        exec("set1",  101, 1'b1, 5'd1, 32'h11);
`ifdef SHIFT_OPS_EN
        exec("sll",   102, 1'b1, 5'd12, 32'h110);
        exec("srl",   103, 1'b1, 5'd13, 32'h1);
`else
        exec("sll",   102, 1'b0, 5'd0, 32'd0);
        exec("srl",   103, 1'b0, 5'd0, 32'd0);
`endif
        exec("stop",  104, 1'b0, 5'd0, 32'd0);
        exec("stop2", 104, 1'b0, 5'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
